sum_divider_seq: RTL



---
 rtl/sum_divider_seq_if.sv | 37 +++
 rtl/sum_divider_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sum_divider_seq_if.sv
// Handshake bundle for sum_divider_seq: dividend input channel, result output channel and busy flag.
// The slave modport is the divider's view; the master modport is the producer/consumer side.
interface sum_divider_seq_if #(
    parameter int WIDTH = 12,
    parameter int DIV_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  busy
    );
endinterface

// File: rtl/sum_divider_seq.sv
// Sequential restoring divider by a constant: one quotient bit per clock, valid/ready on both sides.
// Optional round-to-nearest of the quotient when SUM_DIVIDER_ROUND_EN is defined.
module sum_divider_seq #(
    parameter int WIDTH   = 12,
    parameter int DIVISOR = 3,
    parameter int DIV_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_divider_seq_if.slave  dbus
);

    localparam int                CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W:0]    DIVISOR_C = (DIV_W + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WIDTH - 1);

    generate
        if ((WIDTH < 2) || (DIVISOR < 2) || (DIVISOR > (2 ** DIV_W) - 1)) begin : g_bad_params
            $error("sum_divider_seq: illegal WIDTH/DIVISOR/DIV_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [DIV_W:0]    prem_q;
    logic [WIDTH-1:0]  quo_acc_q;
    logic [WIDTH-1:0]  quotient_q;
    logic [DIV_W-1:0]  remainder_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [DIV_W:0]    prem_shift_s;
    logic              step_ge_s;
    logic [DIV_W:0]    prem_d;
    logic [WIDTH-1:0]  dvd_d;
    logic [WIDTH-1:0]  quo_acc_d;
    logic [WIDTH-1:0]  quo_final_d;
`ifdef SUM_DIVIDER_ROUND_EN
    logic [DIV_W+1:0]  rem_x2_s;
`endif

    // One restoring-division step; the partial remainder is always < DIVISOR so the shift never loses a bit.
    always_comb begin
        prem_shift_s = (prem_q << 1'b1) | {{DIV_W{1'b0}}, dvd_q[WIDTH-1]};
        step_ge_s    = (prem_shift_s >= DIVISOR_C);
        if (step_ge_s) begin
            prem_d = prem_shift_s - DIVISOR_C;
        end else begin
            prem_d = prem_shift_s;
        end
        dvd_d     = dvd_q << 1'b1;
        quo_acc_d = (quo_acc_q << 1'b1) | {{(WIDTH-1){1'b0}}, step_ge_s};
    end

`ifdef SUM_DIVIDER_ROUND_EN
    // Round to nearest on the last step, saturating so the quotient cannot wrap.
    always_comb begin
        rem_x2_s = {prem_d, 1'b0};
        if ((rem_x2_s >= {1'b0, DIVISOR_C}) && (quo_acc_d != {WIDTH{1'b1}})) begin
            quo_final_d = quo_acc_d + WIDTH'(1);
        end else begin
            quo_final_d = quo_acc_d;
        end
    end
`else
    // Truncating division: the final quotient is the accumulated bits as-is.
    always_comb begin
        quo_final_d = quo_acc_d;
    end
`endif

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            prem_q      <= {(DIV_W+1){1'b0}};
            quo_acc_q   <= {WIDTH{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {DIV_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dbus.in_valid) begin
                        dvd_q      <= dbus.in_data;
                        prem_q     <= {(DIV_W+1){1'b0}};
                        quo_acc_q  <= {WIDTH{1'b0}};
                        cnt_q      <= CNT_LOAD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                CALC: begin
                    prem_q    <= prem_d;
                    dvd_q     <= dvd_d;
                    quo_acc_q <= quo_acc_d;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        quotient_q  <= quo_final_d;
                        remainder_q <= prem_d[DIV_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (dbus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle without a result.
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign dbus.in_ready  = in_ready_q;
    assign dbus.out_valid = out_valid_q;
    assign dbus.quotient  = quotient_q;
    assign dbus.remainder = remainder_q;
    assign dbus.busy      = busy_q;

endmodule
